// File: rtl/nrisc_int_ctrl.sv
// nrisc_int_ctrl -- interrupt controller for the NRISC core.
//
// Edge-detects the IRQ lines into PEND, qualifies them with MASK and the
// global enable, and hands the highest-priority request (lowest index) to
// the PC controller as a one-cycle INTERRUPT_flag with an 8-bit vector
// {VEC_BASE, idx}. A grant is only issued while CORE_PC_ctrl is 2'b00.
//
// Config map (cfg_addr):
//   0 MASK  R/W   bit i enables line i
//   1 PEND  R/W1C pending requests
//   2 CTRL  R/W   bit0 GIE, bits7:3 VEC_BASE, bits2:1 read 0
//   3 ISR   R     in-service bits
//
// Optional build macro NRISC_INT_NEST_EN: when defined, a strictly
// higher-priority request preempts the one in service (nested ISR bits,
// int_ret pops the lowest set bit). When undefined, service is single-level.
module nrisc_int_ctrl #(
  parameter int N_IRQ = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic [1:0]       CORE_PC_ctrl,
  input  logic             int_ret,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [7:0]       cfg_wdata,
  output logic [7:0]       cfg_rdata,
  output logic             INTERRUPT_flag,
  output logic [7:0]       INTERRUPT_ch
);

  localparam logic [1:0] ADDR_MASK = 2'd0;
  localparam logic [1:0] ADDR_PEND = 2'd1;
  localparam logic [1:0] ADDR_CTRL = 2'd2;
  localparam logic [1:0] ADDR_ISR  = 2'd3;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_SERVICE = 1'b1
  } state_e;

  // Index of the lowest set bit (0 when the vector is empty).
  function automatic logic [2:0] lowest_idx(input logic [N_IRQ-1:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      idx = v[i] ? 3'(i) : idx;
    end
    return idx;
  endfunction

  // One-hot of the lowest set bit (all zero when the vector is empty).
  function automatic logic [N_IRQ-1:0] lowest_oh(input logic [N_IRQ-1:0] v);
    return v & (~v + N_IRQ'(1));
  endfunction

  // Zero-extend an N_IRQ-wide register to the 8-bit config bus.
  function automatic logic [7:0] pad8(input logic [N_IRQ-1:0] v);
    logic [7:0] r;
    r = 8'h00;
    r[N_IRQ-1:0] = v;
    return r;
  endfunction

  // Registered state
  state_e           state_q,    state_d;
  logic [N_IRQ-1:0] mask_q,     mask_d;
  logic [N_IRQ-1:0] pend_q,     pend_d;
  logic [N_IRQ-1:0] isr_q,      isr_d;
  logic [N_IRQ-1:0] irq_prev_q, irq_prev_d;
  logic             gie_q,      gie_d;
  logic [4:0]       vec_base_q, vec_base_d;
  logic             flag_q,     flag_d;
  logic [7:0]       ch_q,       ch_d;

  // Combinational helpers
  logic [N_IRQ-1:0] edge_s;
  logic [N_IRQ-1:0] eligible_s;
  logic [N_IRQ-1:0] win_oh_s;
  logic [2:0]       win_idx_s;
  logic [N_IRQ-1:0] grant_oh_s;
  logic [N_IRQ-1:0] w1c_s;
  logic [N_IRQ-1:0] ret_clear_s;
  logic             pc_idle_s;
  logic             grant_s;
`ifdef NRISC_INT_NEST_EN
  logic [N_IRQ-1:0] isr_low_s;
`endif

  // Request qualification and winner selection.
  always_comb begin
    edge_s     = irq_in & ~irq_prev_q;
    eligible_s = gie_q ? (pend_q & mask_q) : '0;
    win_oh_s   = lowest_oh(eligible_s);
    win_idx_s  = lowest_idx(eligible_s);
    pc_idle_s  = (CORE_PC_ctrl == 2'b00);
`ifdef NRISC_INT_NEST_EN
    isr_low_s  = lowest_oh(isr_q);
`endif
  end

  // Grant decision: from IDLE always; from SERVICE only when nesting is
  // built in and the winner outranks everything currently in service.
  // Blocking on flag_q keeps the flag from ever being high two cycles in a row.
  always_comb begin
    grant_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        grant_s = (eligible_s != '0) && pc_idle_s;
      end
      ST_SERVICE: begin
`ifdef NRISC_INT_NEST_EN
        // Both operands are one-hot, so a numerically smaller one-hot is a
        // lower index, i.e. a higher priority.
        grant_s = (eligible_s != '0) && pc_idle_s && !flag_q &&
                  (win_oh_s < isr_low_s);
`else
        grant_s = 1'b0;
`endif
      end
      default: begin
        grant_s = 1'b0;
      end
    endcase
  end

  // Return-from-interrupt: pop the lowest in-service bit when nesting,
  // otherwise drop the single in-service bit. Ignored outside SERVICE.
  always_comb begin
    ret_clear_s = '0;
    if ((state_q == ST_SERVICE) && int_ret) begin
`ifdef NRISC_INT_NEST_EN
      ret_clear_s = isr_low_s;
`else
      ret_clear_s = isr_q;
`endif
    end else begin
      ret_clear_s = '0;
    end
  end

  // Next-state for the config, pending and in-service registers.
  always_comb begin
    grant_oh_s = grant_s ? win_oh_s : '0;
    w1c_s      = (cfg_we && (cfg_addr == ADDR_PEND)) ? cfg_wdata[N_IRQ-1:0] : '0;

    mask_d     = (cfg_we && (cfg_addr == ADDR_MASK)) ? cfg_wdata[N_IRQ-1:0] : mask_q;
    gie_d      = (cfg_we && (cfg_addr == ADDR_CTRL)) ? cfg_wdata[0] : gie_q;
    vec_base_d = (cfg_we && (cfg_addr == ADDR_CTRL)) ? cfg_wdata[7:3] : vec_base_q;

    // A fresh edge always sets, even against a W1C or a grant clear.
    pend_d     = (pend_q & ~w1c_s & ~grant_oh_s) | edge_s;
    isr_d      = (isr_q & ~ret_clear_s) | grant_oh_s;
    irq_prev_d = irq_in;

    flag_d     = grant_s;
    ch_d       = grant_s ? {vec_base_q, win_idx_s} : ch_q;
  end

  // FSM transition: enter SERVICE on a grant, leave once nothing is in service.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        state_d = grant_s ? ST_SERVICE : ST_IDLE;
      end
      ST_SERVICE: begin
        state_d = (isr_d == '0) ? ST_IDLE : ST_SERVICE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // All state and output registers; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      mask_q     <= '0;
      pend_q     <= '0;
      isr_q      <= '0;
      irq_prev_q <= '0;
      gie_q      <= 1'b0;
      vec_base_q <= 5'd0;
      flag_q     <= 1'b0;
      ch_q       <= 8'h00;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      pend_q     <= pend_d;
      isr_q      <= isr_d;
      irq_prev_q <= irq_prev_d;
      gie_q      <= gie_d;
      vec_base_q <= vec_base_d;
      flag_q     <= flag_d;
      ch_q       <= ch_d;
    end
  end

  // Config read mux; bits above N_IRQ read as zero.
  always_comb begin
    cfg_rdata = 8'h00;
    case (cfg_addr)
      ADDR_MASK: cfg_rdata = pad8(mask_q);
      ADDR_PEND: cfg_rdata = pad8(pend_q);
      ADDR_CTRL: cfg_rdata = {vec_base_q, 2'b00, gie_q};
      ADDR_ISR:  cfg_rdata = pad8(isr_q);
      default:   cfg_rdata = 8'h00;
    endcase
  end

  assign INTERRUPT_flag = flag_q;
  assign INTERRUPT_ch   = ch_q;

endmodule
